inv_wave_sequencer: RTL and testbench

Sequences each invader wave for the space-invader game. On a level-start pulse it waits a short pre-roll, then releases the level's invader pattern into the 24-bit invader enable bus one row per movement tick. It tracks kills and reports wave-clear or wave-fail to the game controller. It sits between the game controller (lvl_start, level) and the invader ship controller (inv_en, line_crossed), and also selects the invader speed tier.

---
 rtl/inv_wave_sequencer_pkg.sv | 12 +
 rtl/inv_popcount8.sv | 10 +
 rtl/inv_wave_sequencer.sv | 117 +++++++++++
 tb/tb_inv_wave_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/inv_wave_sequencer_pkg.sv
// inv_wave_sequencer_pkg: wave state encoding and per-level pattern/speed tables
package inv_wave_sequencer_pkg;
  localparam int N_INV = 24;
  localparam int ROWS = 3;
  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_SPAWN, S_ACTIVE, S_CLEAR, S_FAIL} wave_state_t;
  function automatic logic [N_INV-1:0] pat(input logic [2:0] level);
    return level == 3'd0 ? 24'h0000FF : level == 3'd1 ? 24'h00FFFF : level == 3'd3 ? 24'hAA55AA : 24'hFFFFFF;
  endfunction
  function automatic logic [1:0] spd(input logic [2:0] level);
    return level == 3'd0 ? 2'd0 : level <= 3'd2 ? 2'd1 : level <= 3'd4 ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/inv_popcount8.sv
// inv_popcount8: combinational population count of one invader row
module inv_popcount8 (
  input  logic [7:0] din,
  output logic [3:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, din[i]};
  end
endmodule

// File: rtl/inv_wave_sequencer.sv
// inv_wave_sequencer: runs one invader wave from level start through pre-roll,
// row-by-row spawn and play, ending in a held clear or fail result
module inv_wave_sequencer
  import inv_wave_sequencer_pkg::*;
#(
  parameter int PRE_TICKS = 4,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             clk_rst,
  input  logic             tick,
  input  logic             lvl_start,
  input  logic [2:0]       level,
  input  logic             hit_valid,
  input  logic [4:0]       hit_idx,
  input  logic             line_crossed,
  output logic [N_INV-1:0] inv_en,
  output logic [1:0]       speed_sel,
  output logic [4:0]       alive_count,
  output logic             wave_busy,
  output logic             wave_clear,
  output logic             wave_fail
);
  wave_state_t state_q, state_d;
  logic [N_INV-1:0] pat_q, pat_d, inv_en_q, inv_en_d, row_mask, hit_mask;
  logic [ROW_W-1:0] row_bits;
  logic [3:0] row_pop, cnt_q, cnt_d;
  logic [4:0] alive_q, alive_d;
  logic [1:0] spd_q, spd_d, row_q, row_d;
  logic busy_q, busy_d, clear_q, clear_d, fail_q, fail_d, spawn, hit_ok;

  inv_popcount8 u_pop (.din(row_bits), .cnt(row_pop));

  always_comb begin
    row_bits = row_q == 2'd0 ? pat_q[ROW_W-1:0] : row_q == 2'd1 ? pat_q[2*ROW_W-1:ROW_W] : pat_q[3*ROW_W-1:2*ROW_W];
    row_mask = {{(N_INV-ROW_W){1'b0}}, row_bits} << (ROW_W * row_q);
    hit_mask = hit_valid && hit_idx < 5'(N_INV) ? {{(N_INV-1){1'b0}}, 1'b1} << hit_idx : '0;
    hit_ok = |(hit_mask & inv_en_q);
    spawn = tick && state_q == S_SPAWN;
  end

  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    spd_d = spd_q;
    inv_en_d = inv_en_q;
    alive_d = alive_q;
    cnt_d = cnt_q;
    row_d = row_q;
    if (lvl_start) begin
      state_d = S_DELAY;
      pat_d = pat(level);
      spd_d = spd(level);
      inv_en_d = '0;
      alive_d = '0;
      cnt_d = 4'(PRE_TICKS);
      row_d = '0;
    end else begin
      case (state_q)
        S_DELAY: if (tick) begin
          cnt_d = cnt_q - 4'd1;
          state_d = cnt_q == 4'd1 ? S_SPAWN : S_DELAY;
          row_d = '0;
        end
        S_SPAWN, S_ACTIVE: if (line_crossed) state_d = S_FAIL;
        else begin
          // a hit is judged against the pre-spawn enables, so it can never kill a bit spawning this cycle
          inv_en_d = (inv_en_q & ~(hit_ok ? hit_mask : '0)) | (spawn ? row_mask : '0);
          alive_d = alive_q + (spawn ? {1'b0, row_pop} : 5'd0) - {4'd0, hit_ok};
          row_d = spawn ? row_q + 2'd1 : row_q;
          state_d = spawn && row_q == 2'(ROWS - 1) ? S_ACTIVE : state_q;
          if (state_q == S_ACTIVE && alive_d == 5'd0) begin
            state_d = S_CLEAR;
            inv_en_d = '0;
          end
        end
        default: ;
      endcase
    end
    busy_d = state_d inside {S_DELAY, S_SPAWN, S_ACTIVE};
    clear_d = state_d == S_CLEAR;
    fail_d = state_d == S_FAIL;
  end

  always_ff @(posedge clk or negedge clk_rst) begin
    if (!clk_rst) begin
      state_q <= S_IDLE;
      pat_q <= '0;
      spd_q <= '0;
      inv_en_q <= '0;
      alive_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
      busy_q <= 1'b0;
      clear_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      spd_q <= spd_d;
      inv_en_q <= inv_en_d;
      alive_q <= alive_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      busy_q <= busy_d;
      clear_q <= clear_d;
      fail_q <= fail_d;
    end
  end

  assign inv_en = inv_en_q;
  assign speed_sel = spd_q;
  assign alive_count = alive_q;
  assign wave_busy = busy_q;
  assign wave_clear = clear_q;
  assign wave_fail = fail_q;
endmodule

// File: tb/tb_inv_wave_sequencer.sv
// tb_inv_wave_sequencer: scenario tasks with a queue of expected output snapshots
module tb_inv_wave_sequencer;
  typedef struct packed {
    logic [23:0] inv;
    logic [4:0]  alive;
    logic [1:0]  spd;
    logic        busy, clr, fail;
  } exp_t;

  logic clk = 1'b0, clk_rst, tick, lvl_start, hit_valid, line_crossed;
  logic [2:0] level;
  logic [4:0] hit_idx, alive_count;
  logic [23:0] inv_en;
  logic [1:0] speed_sel;
  logic wave_busy, wave_clear, wave_fail;
  exp_t sb[$];
  int errors = 0, checks = 0;

  inv_wave_sequencer dut (
    .clk(clk), .clk_rst(clk_rst), .tick(tick), .lvl_start(lvl_start), .level(level),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .line_crossed(line_crossed), .inv_en(inv_en),
    .speed_sel(speed_sel), .alive_count(alive_count), .wave_busy(wave_busy),
    .wave_clear(wave_clear), .wave_fail(wave_fail)
  );

  always #5 clk = ~clk;

  function automatic exp_t obs();
    return {inv_en, alive_count, speed_sel, wave_busy, wave_clear, wave_fail};
  endfunction

  task automatic cyc(input logic t, input logic ls, input logic [2:0] lv, input logic hv, input logic [4:0] hi, input logic lc);
    tick = t; lvl_start = ls; level = lv; hit_valid = hv; hit_idx = hi; line_crossed = lc;
    @(posedge clk); #1;
    tick = 0; lvl_start = 0; hit_valid = 0; line_crossed = 0;
  endtask

  task automatic test_reset;
    exp_t e;
    clk_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset got=%h exp=%h", obs(), e); end
    clk_rst = 1;
    sb.push_back('0);
    cyc(1, 0, 3'd0, 1, 5'd0, 1);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL idle_ignore got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_spawn;
    exp_t e;
    logic [23:0] ei;
    logic [4:0] ea;
    sb.push_back({24'h0, 5'd0, 2'd1, 3'b100});
    cyc(0, 1, 3'd2, 0, 5'd0, 0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL spawn_start got=%h exp=%h", obs(), e); end
    for (int i = 0; i < 7; i++) begin
      ei = i < 4 ? 24'h0 : i == 4 ? 24'h0000FF : i == 5 ? 24'h00FFFF : 24'hFFFFFF;
      ea = i < 4 ? 5'd0 : 5'(8 * (i - 3));
      sb.push_back({ei, ea, 2'd1, 3'b100});
      cyc(1, 0, 3'd0, 0, 5'd0, 0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL spawn_tick%0d got=%h exp=%h", i + 1, obs(), e); end
    end
  endtask

  task automatic test_clear;
    exp_t e;
    logic [7:0] m;
    cyc(0, 1, 3'd0, 0, 5'd0, 0);
    repeat (7) cyc(1, 0, 3'd0, 0, 5'd0, 0);
    sb.push_back({24'h0000FF, 5'd8, 2'd0, 3'b100});
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL clear_spawned got=%h exp=%h", obs(), e); end
    for (int i = 0; i < 8; i++) begin
      m = 8'hFF << (i + 1);
      sb.push_back(i < 7 ? {16'h0, m, 5'(7 - i), 2'd0, 3'b100} : {24'h0, 5'd0, 2'd0, 3'b010});
      cyc(0, 0, 3'd0, 1, 5'(i), 0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL clear_hit%0d got=%h exp=%h", i, obs(), e); end
    end
    sb.push_back({24'h0, 5'd0, 2'd0, 3'b010});
    cyc(1, 0, 3'd0, 1, 5'd0, 1);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL clear_hold got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_invalid_hits;
    exp_t e;
    logic [4:0] idx [4] = '{5'd1, 5'd1, 5'd25, 5'd0};
    sb.push_back({24'h0, 5'd0, 2'd2, 3'b100});
    cyc(0, 1, 3'd3, 0, 5'd0, 0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL inv_start got=%h exp=%h", obs(), e); end
    sb.push_back({24'h0, 5'd0, 2'd2, 3'b100});
    cyc(0, 0, 3'd0, 1, 5'd16, 0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL delay_hit got=%h exp=%h", obs(), e); end
    repeat (7) cyc(1, 0, 3'd0, 0, 5'd0, 0);
    sb.push_back({24'hAA55AA, 5'd12, 2'd2, 3'b100});
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL inv_spawned got=%h exp=%h", obs(), e); end
    for (int i = 0; i < 4; i++) begin
      sb.push_back({24'hAA55A8, 5'd11, 2'd2, 3'b100});
      cyc(0, 0, 3'd0, 1, idx[i], 0);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL inv_hit%0d idx=%0d got=%h exp=%h", i, idx[i], obs(), e); end
    end
  endtask

  task automatic test_simultaneous;
    exp_t e;
    cyc(0, 1, 3'd0, 0, 5'd0, 0);
    repeat (7) cyc(1, 0, 3'd0, 0, 5'd0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 3'd0, 1, 5'(i), 0);
    sb.push_back({24'h000080, 5'd1, 2'd0, 3'b100});
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL one_left got=%h exp=%h", obs(), e); end
    sb.push_back({24'h000080, 5'd1, 2'd0, 3'b001});
    cyc(0, 0, 3'd0, 1, 5'd7, 1);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL hit_and_cross got=%h exp=%h", obs(), e); end
    sb.push_back({24'h000080, 5'd1, 2'd0, 3'b001});
    cyc(1, 0, 3'd0, 1, 5'd7, 0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL fail_hold got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    cyc(0, 1, 3'd2, 0, 5'd0, 0);
    repeat (5) cyc(1, 0, 3'd0, 0, 5'd0, 0);
    sb.push_back({24'h0000FF, 5'd8, 2'd1, 3'b100});
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL b2b_row0 got=%h exp=%h", obs(), e); end
    sb.push_back({24'h00FFF7, 5'd15, 2'd1, 3'b100});
    cyc(1, 0, 3'd0, 1, 5'd3, 0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL spawn_with_hit got=%h exp=%h", obs(), e); end
    sb.push_back({24'h0, 5'd0, 2'd3, 3'b100});
    cyc(1, 1, 3'd5, 0, 5'd0, 0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL restart got=%h exp=%h", obs(), e); end
    repeat (4) cyc(1, 0, 3'd0, 0, 5'd0, 0);
    sb.push_back({24'h0, 5'd0, 2'd3, 3'b100});
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL restart_delay got=%h exp=%h", obs(), e); end
    sb.push_back({24'h0000FF, 5'd8, 2'd3, 3'b100});
    cyc(1, 0, 3'd0, 0, 5'd0, 0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL restart_spawn got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_async_reset;
    exp_t e;
    cyc(0, 1, 3'd4, 0, 5'd0, 0);
    repeat (7) cyc(1, 0, 3'd0, 0, 5'd0, 0);
    sb.push_back({24'hFFFFFF, 5'd24, 2'd2, 3'b100});
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL pre_rst got=%h exp=%h", obs(), e); end
    @(negedge clk);
    clk_rst = 0;
    #1;
    sb.push_back('0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL async_rst got=%h exp=%h", obs(), e); end
    @(posedge clk); #1;
    clk_rst = 1;
    repeat (6) cyc(1, 0, 3'd0, 1, 5'd0, 0);
    sb.push_back('0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL post_rst_tick got=%h exp=%h", obs(), e); end
    sb.push_back({24'h0, 5'd0, 2'd1, 3'b100});
    cyc(0, 1, 3'd1, 0, 5'd0, 0);
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL post_rst_start got=%h exp=%h", obs(), e); end
  endtask

  initial begin
    clk_rst = 0; tick = 0; lvl_start = 0; level = 0; hit_valid = 0; hit_idx = 0; line_crossed = 0;
    test_reset();
    test_spawn();
    test_clear();
    test_invalid_hits();
    test_simultaneous();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
